lagrange_denom: RTL and testbench

LAGRANGE_DENOM -- requirements
Module: lagrange_denom

---
 rtl/lagrange_denom.sv | 151 +++++++++++++++
 tb/tb_lagrange_denom.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lagrange_denom.sv
// Lagrange denominator: product of (x_j - x_i) mod p over streamed peer IDs.
// A bit-serial interleaved multiplier folds each term into the accumulator.
module lagrange_denom #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] p,
    input  logic [W-1:0] x_in,
    input  logic         x_valid,
    input  logic         x_last,
    output logic         x_ready,
    output logic [W-1:0] denom,
    output logic [7:0]   term_cnt,
    output logic         busy,
    output logic         done,
    output logic         error
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {IDLE, WAIT_X, DIFF, MUL, DONE} state_t;

    state_t state, state_nxt;

    logic [W-1:0]  xi_q, p_q, xj_q, d_q, acc, r;
    logic          last_q;
    logic [CW-1:0] bit_cnt;
    logic          p_bad, same, mul_end;
    logic [W-1:0]  diff, r_nxt;
    logic [W:0]    p_ext, dbl, dbl_red, sum;

    assign p_bad   = ~|p[W-1:1];
    assign same    = (xj_q == xi_q);
    assign mul_end = (bit_cnt == CW'(W - 1));
    assign p_ext   = {1'b0, p_q};

    always_comb begin
        if (xj_q >= xi_q)
            diff = xj_q - xi_q;
        else
            diff = W'({1'b0, xj_q} + p_ext - {1'b0, xi_q});
    end

    // One MSB-first step: r = 2r mod p, then add acc when the d bit is set.
    always_comb begin
        dbl     = {r, 1'b0};
        dbl_red = (dbl >= p_ext) ? dbl - p_ext : dbl;
        sum     = dbl_red + {1'b0, acc};
        r_nxt   = dbl_red[W-1:0];
        if (d_q[W-1])
            r_nxt = (sum >= p_ext) ? W'(sum - p_ext) : sum[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = p_bad ? DONE : WAIT_X;
            end
            WAIT_X: begin
                x_ready = 1'b1;
                if (x_valid)
                    state_nxt = DIFF;
            end
            DIFF: begin
                if (!same)
                    state_nxt = MUL;
                else
                    state_nxt = last_q ? DONE : WAIT_X;
            end
            MUL: begin
                if (mul_end)
                    state_nxt = last_q ? DONE : WAIT_X;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xi_q     <= '0;
            p_q      <= '0;
            xj_q     <= '0;
            d_q      <= '0;
            acc      <= '0;
            r        <= '0;
            last_q   <= 1'b0;
            bit_cnt  <= '0;
            denom    <= '0;
            term_cnt <= '0;
            error    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        xi_q     <= x_i;
                        p_q      <= p;
                        acc      <= W'(1);
                        term_cnt <= '0;
                        error    <= p_bad;
                        if (p_bad)
                            denom <= '0;
                    end
                end
                WAIT_X: begin
                    if (x_valid) begin
                        xj_q   <= x_in;
                        last_q <= x_last;
                    end
                end
                DIFF: begin
                    d_q     <= diff;
                    r       <= '0;
                    bit_cnt <= '0;
                    if (same && last_q)
                        denom <= acc;
                end
                MUL: begin
                    r       <= r_nxt;
                    d_q     <= {d_q[W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CW'(1);
                    if (mul_end) begin
                        acc <= r_nxt;
                        if (term_cnt != 8'hFF)
                            term_cnt <= term_cnt + 8'd1;
                        if (last_q)
                            denom <= r_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lagrange_denom.sv
// Directed bench for lagrange_denom with a result scoreboard.
module tb_lagrange_denom;
    localparam int W = 256;

    typedef struct {
        logic [W-1:0] d;
        logic [7:0]   c;
        logic         e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] x_i = '0;
    logic [W-1:0] p = '0;
    logic [W-1:0] x_in = '0;
    logic         x_valid = 1'b0;
    logic         x_last = 1'b0;
    logic         x_ready;
    logic [W-1:0] denom;
    logic [7:0]   term_cnt;
    logic         busy;
    logic         done;
    logic         error;

    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    lagrange_denom #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .x_i(x_i), .p(p),
        .x_in(x_in), .x_valid(x_valid), .x_last(x_last),
        .x_ready(x_ready), .denom(denom), .term_cnt(term_cnt),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [W-1:0] xi,
                                           input logic [W-1:0] pp,
                                           input logic [W-1:0] xs[$]);
        logic [2*W-1:0] a, d, pw;
        pw = {{W{1'b0}}, pp};
        a  = 1;
        foreach (xs[k]) begin
            if (xs[k] != xi) begin
                d = ({{W{1'b0}}, xs[k]} + pw - {{W{1'b0}}, xi}) % pw;
                a = (a * d) % pw;
            end
        end
        return a[W-1:0];
    endfunction

    task automatic push(input logic [W-1:0] d, input logic [7:0] c,
                        input logic e);
        exp_t t;
        t.d = d;
        t.c = c;
        t.e = e;
        sb.push_back(t);
        pushes++;
    endtask

    always @(negedge clk) begin
        if (done) begin
            exp_t t;
            done_cnt++;
            chk("done_single", W'(prev_done), W'(0));
            if (sb.size() == 0) begin
                chk("sb_nonempty", W'(0), W'(1));
            end else begin
                t = sb.pop_front();
                chk("denom", denom, t.d);
                chk("term_cnt", W'(term_cnt), W'(t.c));
                chk("error", W'(error), W'(t.e));
            end
        end
        prev_done = done;
    end

    task automatic do_start(input logic [W-1:0] xi, input logic [W-1:0] pp);
        @(negedge clk);
        start = 1'b1;
        x_i   = xi;
        p     = pp;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns just after the transfer edge; low counts x_ready-low cycles.
    task automatic send(input logic [W-1:0] x, input logic lst,
                        output int low);
        low     = 0;
        x_in    = x;
        x_last  = lst;
        x_valid = 1'b1;
        while (!x_ready && low <= 2000) begin
            @(posedge clk);
            #1;
            low++;
        end
        if (low > 2000)
            chk("x_ready_timeout", W'(0), W'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n <= 3000);
        if (n > 3000)
            chk("done_timeout", W'(0), W'(1));
    endtask

    initial begin
        int low, n;
        logic [W-1:0] big_p, rp, rxi, r1, r2;
        logic [W-1:0] xs[$];

        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_x_ready", W'(x_ready), W'(0));
        chk("rst_denom", denom, W'(0));
        chk("rst_term_cnt", W'(term_cnt), W'(0));
        chk("rst_error", W'(error), W'(0));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", W'(busy), W'(0));

        // x_i=2, p=13, x={1,3,5}
        do_start(W'(2), W'(13));
        push(W'(10), 8'd3, 1'b0);
        send(W'(1), 1'b0, low);
        chk("low_first", W'(low), W'(0));
        send(W'(3), 1'b0, low);
        chk("low_mul1", W'(low), W'(257));
        send(W'(5), 1'b1, low);
        chk("low_mul2", W'(low), W'(257));
        x_valid = 1'b0;
        wait_done(n);
        chk("lat_mul_last", W'(n), W'(258));
        repeat (5) @(negedge clk);
        chk("hold_denom", denom, W'(10));
        chk("hold_cnt", W'(term_cnt), W'(3));
        chk("hold_busy", W'(busy), W'(0));

        // only element equals x_i
        do_start(W'(3), W'(13));
        push(W'(1), 8'd0, 1'b0);
        send(W'(3), 1'b1, low);
        x_valid = 1'b0;
        wait_done(n);
        chk("lat_skip", W'(n), W'(2));

        // invalid modulus
        @(negedge clk);
        start = 1'b1;
        x_i   = W'(4);
        p     = W'(1);
        push(W'(0), 8'd0, 1'b1);
        @(posedge clk);
        #1;
        chk("perr_done", W'(done), W'(1));
        chk("perr_x_ready", W'(x_ready), W'(0));
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("perr_hold_err", W'(error), W'(1));
        chk("perr_x_ready2", W'(x_ready), W'(0));

        // start while busy is ignored
        do_start(W'(4), W'(13));
        push(W'(5), 8'd1, 1'b0);
        send(W'(9), 1'b1, low);
        x_valid = 1'b0;
        repeat (20) @(negedge clk);
        start = 1'b1;
        x_i   = W'(0);
        p     = W'(7);
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_busy", W'(busy), W'(1));
        wait_done(n);
        chk("busy_start_lat", W'(n), W'(258 - 21));

        // full-width modulus 2^255-19
        big_p = (W'(1) << 255) - W'(19);
        do_start(W'(1), big_p);
        push(big_p - W'(2), 8'd1, 1'b0);
        send(big_p - W'(1), 1'b1, low);
        x_valid = 1'b0;
        wait_done(n);

        // random wide modulus, skip in the middle of the set
        rp = '0;
        for (int k = 0; k < W / 32; k++)
            rp = (rp << 32) | W'($urandom);
        rp[W-1] = 1'b1;
        rxi = W'(({$urandom, $urandom, $urandom, $urandom}) % rp);
        r1  = W'(({$urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom}) % {1'b0, rp});
        r2  = rp - W'(1);
        if (r1 == rxi)
            r1 = rxi + W'(1);
        xs = {r1, rxi, r2};
        do_start(rxi, rp);
        push(model(rxi, rp, xs), 8'd2, 1'b0);
        send(r1, 1'b0, low);
        send(rxi, 1'b0, low);
        chk("low_after_mul", W'(low), W'(257));
        send(r2, 1'b1, low);
        chk("low_after_skip", W'(low), W'(1));
        x_valid = 1'b0;
        wait_done(n);

        // reset in the middle of a multiply
        do_start(W'(2), W'(13));
        send(W'(7), 1'b1, low);
        x_valid = 1'b0;
        @(posedge clk);
        repeat (100) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        chk("abort_x_ready", W'(x_ready), W'(0));
        chk("abort_denom", denom, W'(0));
        chk("abort_cnt", W'(term_cnt), W'(0));
        chk("abort_error", W'(error), W'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_idle", W'(busy), W'(0));

        do_start(W'(2), W'(13));
        push(W'(10), 8'd3, 1'b0);
        send(W'(1), 1'b0, low);
        send(W'(3), 1'b0, low);
        send(W'(5), 1'b1, low);
        x_valid = 1'b0;
        wait_done(n);

        repeat (3) @(negedge clk);
        chk("done_count", W'(done_cnt), W'(pushes));
        chk("sb_drained", W'(sb.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
